// File: rtl/traffic_monitor_if.sv
// traffic_monitor_if -- signal bundle between a lamp driver and the monitor.
//   master : drives enable, clear and the three lamp inputs; observes status.
//   slave  : the monitor side; samples lamps, returns locked/error/count status.
// CNT_W sets the width of err_count and seq_count and must match the monitor.
interface traffic_monitor_if #(
    parameter int unsigned CNT_W = 8
);
    logic             enable;
    logic             clear;
    logic             red;
    logic             amber;
    logic             green;
    logic             locked;
    logic             err_pulse;
    logic [1:0]       err_code;
    logic             err_sticky;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] seq_count;

    modport master (
        output enable, clear, red, amber, green,
        input  locked, err_pulse, err_code, err_sticky, err_count, seq_count
    );

    modport slave (
        input  enable, clear, red, amber, green,
        output locked, err_pulse, err_code, err_sticky, err_count, seq_count
    );
endinterface

// File: rtl/traffic_monitor.sv
// traffic_monitor -- checks an observed traffic-light lamp pattern each cycle.
//   clk        : rising-edge system clock
//   rst_n      : asynchronous active-low reset
//   bus.enable : sample/check lamps when high; low forces UNLOCKED
//   bus.clear  : synchronous clear of err_sticky, err_count, seq_count
//   bus.red/amber/green : observed lamps, pattern P = {red,amber,green}
//   bus.locked     : monitor synchronised to a legal pattern
//   bus.err_pulse  : one-cycle error flag for the previous sample
//   bus.err_code   : 00 none, 01 illegal, 10 sequence, 11 stall
//   bus.err_sticky : latched error flag
//   bus.err_count  : saturating error count
//   bus.seq_count  : wrapping count of completed 010->100 cycles
// All outputs are registered (one-cycle latency).
module traffic_monitor #(
    parameter int unsigned HOLD_MAX = 1,
    parameter int unsigned CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    traffic_monitor_if.slave   bus
);

    typedef enum logic {
        S_UNLOCKED = 1'b0,
        S_LOCKED   = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        E_NONE    = 2'b00,
        E_ILLEGAL = 2'b01,
        E_SEQ     = 2'b10,
        E_STALL   = 2'b11
    } err_e;

    localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

    state_e           state_q, state_d;
    logic [2:0]       l_q, l_d;
    logic [7:0]       h_q, h_d;
    logic             pulse_q, pulse_d;
    err_e             code_q, code_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] errcnt_q, errcnt_d;
    logic [CNT_W-1:0] seqcnt_q, seqcnt_d;

    logic [2:0] pat;
    logic       pat_legal;
    logic [2:0] succ;

    assign pat = {bus.red, bus.amber, bus.green};

    always_comb begin
        pat_legal = (pat == 3'b100) || (pat == 3'b110) ||
                    (pat == 3'b001) || (pat == 3'b010);
    end

    always_comb begin
        succ = 3'b100;
        case (l_q)
            3'b100:  succ = 3'b110;
            3'b110:  succ = 3'b001;
            3'b001:  succ = 3'b010;
            3'b010:  succ = 3'b100;
            default: succ = 3'b100;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        l_d      = l_q;
        h_d      = h_q;
        code_d   = E_NONE;
        pulse_d  = 1'b0;
        sticky_d = sticky_q;
        errcnt_d = errcnt_q;
        seqcnt_d = seqcnt_q;

        if (!bus.enable) begin
            state_d = S_UNLOCKED;
        end else if (state_q == S_UNLOCKED) begin
            if (pat_legal) begin
                state_d = S_LOCKED;
                l_d     = pat;
                h_d     = 8'd1;
            end else begin
                code_d = E_ILLEGAL;
            end
        end else begin
            // Priority: illegal > sequence > stall. A repeat of L is never a
            // sequence error; only a legal pattern that is neither L nor its
            // successor resyncs with error 10.
            if (!pat_legal) begin
                code_d  = E_ILLEGAL;
                state_d = S_UNLOCKED;
            end else if (pat == succ) begin
                l_d = pat;
                h_d = 8'd1;
                if (l_q == 3'b010) begin
                    seqcnt_d = seqcnt_q + 1'b1;
                end
            end else if (pat == l_q) begin
                if (h_q < HOLD_LIM) begin
                    h_d = h_q + 8'd1;
                end else begin
                    code_d = E_STALL;
                    h_d    = 8'd1;
                end
            end else begin
                code_d = E_SEQ;
                l_d    = pat;
                h_d    = 8'd1;
            end
        end

        if (code_d != E_NONE) begin
            pulse_d  = 1'b1;
            sticky_d = 1'b1;
            if (errcnt_q != '1) begin
                errcnt_d = errcnt_q + 1'b1;
            end
        end

        // Clear wins over any same-cycle set/increment; pulse/code unaffected.
        if (bus.clear) begin
            sticky_d = 1'b0;
            errcnt_d = '0;
            seqcnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_UNLOCKED;
            l_q      <= 3'b100;
            h_q      <= '0;
            pulse_q  <= 1'b0;
            code_q   <= E_NONE;
            sticky_q <= 1'b0;
            errcnt_q <= '0;
            seqcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            l_q      <= l_d;
            h_q      <= h_d;
            pulse_q  <= pulse_d;
            code_q   <= code_d;
            sticky_q <= sticky_d;
            errcnt_q <= errcnt_d;
            seqcnt_q <= seqcnt_d;
        end
    end

    assign bus.locked     = (state_q == S_LOCKED);
    assign bus.err_pulse  = pulse_q;
    assign bus.err_code   = code_q;
    assign bus.err_sticky = sticky_q;
    assign bus.err_count  = errcnt_q;
    assign bus.seq_count  = seqcnt_q;

endmodule

// File: tb/tb_traffic_monitor.sv
// tb_traffic_monitor -- directed bench for traffic_monitor.
// Two instances: u_a (HOLD_MAX=1, CNT_W=8) and u_b (HOLD_MAX=3, CNT_W=2).
module tb_traffic_monitor;

    logic clk;
    logic rst_n;
    int unsigned n_total;
    int unsigned n_pass;

    traffic_monitor_if #(.CNT_W(8)) ifa ();
    traffic_monitor_if #(.CNT_W(2)) ifb ();

    traffic_monitor #(.HOLD_MAX(1), .CNT_W(8)) u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa.slave)
    );

    traffic_monitor #(.HOLD_MAX(3), .CNT_W(2)) u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive a pattern on A, advance one rising edge, sample 1 time unit later.
    task automatic step_a(input logic [2:0] p);
        {ifa.red, ifa.amber, ifa.green} = p;
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input logic [2:0] p);
        {ifb.red, ifb.amber, ifb.green} = p;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic lk, input logic pl,
                         input logic [1:0] cd, input logic st,
                         input logic [7:0] ec, input logic [7:0] sc);
        check({tag, ".locked"}, 32'(ifa.locked),     32'(lk));
        check({tag, ".pulse"},  32'(ifa.err_pulse),  32'(pl));
        check({tag, ".code"},   32'(ifa.err_code),   32'(cd));
        check({tag, ".sticky"}, 32'(ifa.err_sticky), 32'(st));
        check({tag, ".errcnt"}, 32'(ifa.err_count),  32'(ec));
        check({tag, ".seqcnt"}, 32'(ifa.seq_count),  32'(sc));
    endtask

    logic [2:0] cyc [4];

    initial begin
        n_total = 0;
        n_pass  = 0;
        cyc[0] = 3'b100; cyc[1] = 3'b110; cyc[2] = 3'b001; cyc[3] = 3'b010;

        rst_n = 1'b0;
        ifa.enable = 1'b0; ifa.clear = 1'b0; {ifa.red, ifa.amber, ifa.green} = 3'b000;
        ifb.enable = 1'b0; ifb.clear = 1'b0; {ifb.red, ifb.amber, ifb.green} = 3'b000;
        #23;
        chk_a("reset", 1'b0, 1'b0, 2'b00, 1'b0, 8'd0, 8'd0);
        rst_n = 1'b1;

        // Three full cycles; the first red only locks, two 010->100 completions.
        ifa.enable = 1'b1;
        for (int unsigned r = 0; r < 3; r++) begin
            for (int unsigned k = 0; k < 4; k++) begin
                step_a(cyc[k]);
                if (r == 0 && k == 0) chk_a("first_lock", 1'b1, 1'b0, 2'b00, 1'b0, 8'd0, 8'd0);
                else check("cycle.pulse", 32'(ifa.err_pulse), 32'd0);
            end
        end
        chk_a("three_cycles", 1'b1, 1'b0, 2'b00, 1'b0, 8'd0, 8'd2);

        // Illegal while locked on 110, then relock on 001.
        step_a(3'b100);
        check("wrap.seqcnt", 32'(ifa.seq_count), 32'd3);
        step_a(3'b110);
        step_a(3'b111);
        chk_a("illegal", 1'b0, 1'b1, 2'b01, 1'b1, 8'd1, 8'd3);
        step_a(3'b001);
        chk_a("relock", 1'b1, 1'b0, 2'b00, 1'b1, 8'd1, 8'd3);

        // Sequence violation 100 -> 001, then 010 accepted after resync.
        step_a(3'b010);
        step_a(3'b100);
        step_a(3'b001);
        chk_a("seqerr", 1'b1, 1'b1, 2'b10, 1'b1, 8'd2, 8'd4);
        step_a(3'b010);
        chk_a("resync", 1'b1, 1'b0, 2'b00, 1'b1, 8'd2, 8'd4);

        // HOLD_MAX=1: any repeat is a stall.
        step_a(3'b010);
        chk_a("stall1", 1'b1, 1'b1, 2'b11, 1'b1, 8'd3, 8'd4);

        // Clear together with a stall: pulse/code reported, counters zeroed.
        ifa.clear = 1'b1;
        step_a(3'b010);
        ifa.clear = 1'b0;
        chk_a("clear", 1'b1, 1'b1, 2'b11, 1'b0, 8'd0, 8'd0);

        // Build some state, then async reset between edges.
        step_a(3'b100);
        step_a(3'b100);
        chk_a("pre_rst", 1'b1, 1'b1, 2'b11, 1'b1, 8'd1, 8'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk_a("async_rst", 1'b0, 1'b0, 2'b00, 1'b0, 8'd0, 8'd0);
        #2;
        rst_n = 1'b1;

        // Enable low with 000 driven: no errors, stays unlocked.
        ifa.enable = 1'b0;
        for (int unsigned k = 0; k < 4; k++) begin
            step_a(3'b000);
            check("dis.pulse",  32'(ifa.err_pulse), 32'd0);
            check("dis.locked", 32'(ifa.locked),    32'd0);
        end
        ifa.enable = 1'b1;
        step_a(3'b100);
        chk_a("en_lock", 1'b1, 1'b0, 2'b00, 1'b0, 8'd0, 8'd0);
        ifa.enable = 1'b0;
        step_a(3'b100);
        check("dis_unlock", 32'(ifa.locked), 32'd0);
        // Re-enable on a non-successor legal pattern: plain lock, no error.
        ifa.enable = 1'b1;
        step_a(3'b001);
        chk_a("reen_lock", 1'b1, 1'b0, 2'b00, 1'b0, 8'd0, 8'd0);
        ifa.enable = 1'b0;

        // Instance B, HOLD_MAX=3: 001 held four samples stalls on the 4th.
        ifb.enable = 1'b1;
        step_b(3'b110);
        check("b.lock", 32'(ifb.locked), 32'd1);
        for (int unsigned k = 0; k < 3; k++) begin
            step_b(3'b001);
            check("b.hold.pulse", 32'(ifb.err_pulse), 32'd0);
        end
        step_b(3'b001);
        check("b.stall.pulse", 32'(ifb.err_pulse), 32'd1);
        check("b.stall.code",  32'(ifb.err_code),  32'd3);
        step_b(3'b001);
        check("b.after.pulse", 32'(ifb.err_pulse), 32'd0);
        check("b.after.errcnt", 32'(ifb.err_count), 32'd1);
        step_b(3'b001);
        check("b.h3.pulse", 32'(ifb.err_pulse), 32'd0);

        // Five illegal samples saturate the 2-bit error counter at 3.
        step_b(3'b000);
        check("b.ill1.locked", 32'(ifb.locked),    32'd0);
        check("b.ill1.errcnt", 32'(ifb.err_count), 32'd2);
        step_b(3'b011);
        check("b.ill2.errcnt", 32'(ifb.err_count), 32'd3);
        step_b(3'b101);
        step_b(3'b111);
        step_b(3'b000);
        check("b.sat.errcnt", 32'(ifb.err_count), 32'd3);
        check("b.sat.code",   32'(ifb.err_code),  32'd1);
        ifb.clear = 1'b1;
        step_b(3'b111);
        ifb.clear = 1'b0;
        check("b.clr.pulse",  32'(ifb.err_pulse),  32'd1);
        check("b.clr.code",   32'(ifb.err_code),   32'd1);
        check("b.clr.errcnt", 32'(ifb.err_count),  32'd0);
        check("b.clr.sticky", 32'(ifb.err_sticky), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/traffic_monitor.md
TRAFFIC_MONITOR -- requirements
Module: traffic_monitor

Interface
REQ-001 Parameter HOLD_MAX, default 1, max consecutive samples one light pattern may persist (range 1-255).
REQ-002 Parameter CNT_W, default 8, width of err_count and seq_count.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst_n  input  1  one clock; reset is asynchronous and active-low.
REQ-005 enable  input  1  high: sample and check lights each cycle; low: checking suspended.
REQ-006 clear  input  1  synchronous clear of err_sticky, err_count, seq_count.
REQ-007 red  input  1  observed red lamp.
REQ-008 amber  input  1  observed amber lamp.
REQ-009 green  input  1  observed green lamp.
REQ-010 locked  output  1  monitor synchronised to a legal pattern.
REQ-011 err_pulse  output  1  one-cycle flag, error detected on the last sample.
REQ-012 err_code  output  2  00 none, 01 illegal pattern, 10 sequence violation, 11 stall; valid while err_pulse high, else 00.
REQ-013 err_sticky  output  1  set by any error, held until clear or reset.
REQ-014 err_count  output  CNT_W  number of errors, saturating.
REQ-015 seq_count  output  CNT_W  completed full cycles, wrapping.

Function
REQ-016 Pattern P = {red,amber,green}; legal patterns SHALL be 100, 110, 001, 010 only; 000, 011, 101, 111 are illegal.
REQ-017 Legal successor SHALL be 100->110->001->010->100.
REQ-018 Two states SHALL exist: UNLOCKED, LOCKED; register last pattern L and hold counter H (8-bit).
REQ-019 All outputs SHALL be registered; the response to P sampled at edge n appears after edge n (one-cycle latency).
REQ-020 UNLOCKED, enable=1: legal P -> LOCKED, L=P, H=1, no error; illegal P -> stay UNLOCKED, err code 01.
REQ-021 LOCKED, enable=1: checks in priority order illegal(01) > sequence(10) > stall(11).
REQ-022 LOCKED, P illegal -> error 01, go UNLOCKED.
REQ-023 LOCKED, P legal and not L nor successor(L) -> error 10, stay LOCKED, L=P, H=1 (resync).
REQ-024 LOCKED, P==successor(L) -> no error, L=P, H=1.
REQ-025 LOCKED, P==L and H<HOLD_MAX -> no error, H=H+1.
REQ-026 LOCKED, P==L and H==HOLD_MAX -> error 11, H=1, stay LOCKED.
REQ-027 seq_count SHALL increment on each error-free LOCKED transition 010->100; wraps from all-ones to 0.
REQ-028 err_count SHALL increment on each err_pulse; saturates at 2^CNT_W-1.
REQ-029 err_sticky SHALL set on each err_pulse.
REQ-030 clear=1 SHALL zero err_sticky, err_count, seq_count, overriding any same-cycle increment or set; err_pulse/err_code still report that cycle's error.
REQ-031 enable=0 SHALL force UNLOCKED, err_pulse=0, err_code=00, hold counters; next enabled sample treated per REQ-020.
REQ-032 locked SHALL equal (state==LOCKED).

Reset
REQ-033 rst_n low SHALL immediately set state UNLOCKED, L=100, H=0, locked=0, err_pulse=0, err_code=00, err_sticky=0, err_count=0, seq_count=0.
REQ-034 rst_n deasserted SHALL take effect at the next rising edge; reset mid-sequence SHALL discard all history.

Verification
REQ-035 HOLD_MAX=1, enable=1, drive 100,110,001,010 repeated 3 times -> locked=1 after first edge, err_sticky=0, seq_count=2 (first red only locks).
REQ-036 Locked on 110, drive 111 -> err_pulse=1, err_code=01, locked=0, err_count=1; then 001 -> locked=1, no error.
REQ-037 Locked on 100, drive 001 -> err_code=10, locked stays 1; then 010 -> no error.
REQ-038 HOLD_MAX=3, hold 001 for 4 samples -> no error for first 3, err_code=11 on 4th; 5th 001 accepted (H=2).
REQ-039 CNT_W=2, force 5 illegal samples -> err_count=3; assert clear together with 6th illegal -> err_pulse=1, err_count=0, err_sticky=0.
REQ-040 Drop rst_n asynchronously between edges mid-sequence -> outputs zero immediately; enable=0 for 4 cycles with 000 driven -> no err_pulse.
